hand_tracker: RTL and testbench
===============================

Name: hand_tracker

Overview:
- Per-frame hand-state stage directly upstream of the player-1 hand sprite renderer.
- Takes raw hand centroid and open/closed samples from the vision path and smooths the position.
- Debounces the closed flag and runs the grab/hold/throw state machine.
- Outputs x, y, closed and ball_state only on frame boundaries, so the sprite never tears mid-frame.

Parameters:
- SMOOTH_SHIFT, 2: position filter gain; each frame moves 1/2^SMOOTH_SHIFT of the way to the target (0 = jump directly).
- DEBOUNCE_FRAMES, 3: consecutive disagreeing frames required to flip closed.
- GRAB_RADIUS, 32: max |dx| and max |dy| between hand and ball for a grab (Chebyshev box).
- LOST_FRAMES, 8: frames without a valid sample before lost asserts.

Ports:
- clk  in  1  system pixel clock
- reset  in  1  synchronous, active-high reset
- new_frame  in  1  one-cycle strobe at start of vertical blank
- raw_valid  in  1  raw sample strobe (any number per frame)
- raw_x  in  16  raw hand centroid x (unsigned pixels)
- raw_y  in  16  raw hand centroid y
- raw_closed  in  1  raw fist detection for this sample
- ball_x  in  16  current ball position x
- ball_y  in  16  current ball position y
- ball_landed  in  1  one-cycle pulse from ball physics, ball came to rest
- x  out  16  smoothed hand x
- y  out  16  smoothed hand y
- closed  out  1  debounced fist flag
- ball_state  out  2  0 FREE, 1 HELD, 2 THROWN (3 never driven)
- throw_vx  out  16  signed per-frame x velocity latched at release
- throw_vy  out  16  signed per-frame y velocity latched at release
- grab  out  1  one-cycle pulse on FREE->HELD
- release  out  1  one-cycle pulse on HELD->THROWN
- lost  out  1  hand not seen for LOST_FRAMES frames

Behaviour:
Reset values:
- x=320, y=240, closed=0, ball_state=FREE, throw_vx=0, throw_vy=0, grab=0, release=0, lost=1.
- Shadow registers cleared, lost_cnt=LOST_FRAMES, debounce count=0.

Sampling:
- On raw_valid, latch raw_x, raw_y, raw_closed into shadow registers and set seen=1. The last sample in a frame wins.
- If raw_valid and new_frame coincide, the frame update uses the shadow contents from before the sample. The sample is then written to shadow and seen=1 for the next frame.

Frame update (registered; all outputs change on the cycle after new_frame, latency 1):
- seen=0:
  - x, y hold; debounce count holds.
  - lost_cnt saturating increments; lost=1 when lost_cnt >= LOST_FRAMES.
- seen=1:
  - lost_cnt=0, lost=0.
  - Position: d = {1'b0,shadow} - {1'b0,cur}, 17-bit signed; step = d >>> SMOOTH_SHIFT (arithmetic).
  - If step==0 and d!=0, step = sign(d) (+1 or -1), which guarantees convergence.
  - new = cur + step, truncated to 16 bits (no wrap possible since the target is in range).
  - Debounce: if shadow_closed != closed, count++; when count reaches DEBOUNCE_FRAMES, flip closed and clear count. If equal, clear count.
- seen is cleared after every frame update.
- prev_x and prev_y register the pre-update x, y each frame for velocity.

Ball state machine (evaluated in the same frame-update cycle, using the newly computed closed, x, y):
- FREE -> HELD: closed rises this update AND |x-ball_x| <= GRAB_RADIUS AND |y-ball_y| <= GRAB_RADIUS. Pulse grab.
- A rise outside the box leaves the FSM in FREE. A fist already closed when entering the box does not grab; a fresh rise is required.
- HELD -> THROWN when closed falls:
  - throw_vx = x_new - prev_x, throw_vy = y_new - prev_y (16-bit two's complement).
  - Pulse release.
- HELD -> THROWN when lost rises this update: drop with throw_vx = throw_vy = 0; pulse release.
- THROWN -> FREE on a ball_landed pulse, in any cycle (not frame-gated).
  - If ball_landed coincides with a frame update, return to FREE first; a grab cannot occur in the same cycle.
- ball_landed in FREE or HELD is ignored.
- grab and release are high for exactly one clk.
- Reset mid-operation returns all state to reset values on the next edge, regardless of FSM state.

Test Plan:
1. Reset, SMOOTH_SHIFT=2: one raw_valid (400,240) per frame. After frame 1, x=340; after frame 2, x=355; x reaches exactly 400 and then holds.
2. raw_closed=1 in 2 frames then 0: closed stays 0. 3 consecutive frames of 1: closed=1 on the cycle after the 3rd new_frame.
3. Hand at (100,100), ball at (130,70), close the fist: grab pulses once, ball_state=1. Repeat with the ball at (133,100): no grab, ball_state=0.
4. While HELD, move from x=200 to a target giving x_new=215, then open the fist: ball_state=2, throw_vx=15, throw_vy=0, release pulses. Then ball_landed: ball_state=0.
5. While HELD, stop raw_valid for 8 frames: lost=1, ball_state=2, throw_vx=throw_vy=0. x and y hold their last values throughout.
6. raw_valid with (50,50) in the same cycle as new_frame: that frame's update ignores it. The next frame moves toward (50,50). Assert reset while THROWN: all outputs return to reset values.

Source files
------------

// File: rtl/hand_tracker_if.sv
// Hand tracker signal bundle: vision samples, ball position/landing in; frame-aligned hand state out.
// master drives the i_* inputs of the tracker; slave is the tracker itself.
interface hand_tracker_if;
  logic        i_new_frame;
  logic        i_raw_valid;
  logic [15:0] i_raw_x;
  logic [15:0] i_raw_y;
  logic        i_raw_closed;
  logic [15:0] i_ball_x;
  logic [15:0] i_ball_y;
  logic        i_ball_landed;
  logic [15:0] o_x;
  logic [15:0] o_y;
  logic        o_closed;
  logic [1:0]  o_ball_state;
  logic [15:0] o_throw_vx;
  logic [15:0] o_throw_vy;
  logic        o_grab;
  logic        o_release;
  logic        o_lost;

  modport master (
    output i_new_frame, i_raw_valid, i_raw_x, i_raw_y, i_raw_closed,
    output i_ball_x, i_ball_y, i_ball_landed,
    input  o_x, o_y, o_closed, o_ball_state, o_throw_vx, o_throw_vy,
    input  o_grab, o_release, o_lost
  );

  modport slave (
    input  i_new_frame, i_raw_valid, i_raw_x, i_raw_y, i_raw_closed,
    input  i_ball_x, i_ball_y, i_ball_landed,
    output o_x, o_y, o_closed, o_ball_state, o_throw_vx, o_throw_vy,
    output o_grab, o_release, o_lost
  );
endinterface

// File: rtl/hand_tracker.sv
// Smooths hand position, debounces the fist flag and runs grab/hold/throw; outputs move only on frames.
// Latency: 1 cycle after new_frame (ball_landed acts on the next edge); no backpressure, samples always taken.
module hand_tracker #(
  parameter int SMOOTH_SHIFT    = 2,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int GRAB_RADIUS     = 32,
  parameter int LOST_FRAMES     = 8
) (
  input  logic          clk,
  input  logic          reset,
  hand_tracker_if.slave bus
);
  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_HELD = 2'd1, ST_THROWN = 2'd2} state_t;

  localparam int LCW = $clog2(LOST_FRAMES + 1);
  localparam int DCW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [15:0]    r_sh_x, r_sh_y;
  logic           r_sh_closed, r_seen;
  logic [15:0]    r_x, r_y, r_vx, r_vy;
  logic           r_closed, r_lost, r_grab, r_release;
  logic [DCW-1:0] r_db_cnt;
  logic [LCW-1:0] r_lost_cnt;
  state_t         r_state;

  logic [15:0]    w_x, w_y, w_vx, w_vy;
  logic           w_closed, w_lost, w_grab, w_release;
  logic [DCW-1:0] w_db_cnt, w_db_inc;
  logic [LCW-1:0] w_lost_cnt;
  state_t         w_state;

  // Minimum step of one pixel keeps the filter from stalling short of the target.
  function automatic logic [15:0] smooth(input logic [15:0] cur, input logic [15:0] tgt);
    logic signed [16:0] d, step;
    d    = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = d >>> SMOOTH_SHIFT;
    if (step == 17'sd0 && d != 17'sd0) step = d[16] ? -17'sd1 : 17'sd1;
    return cur + step[15:0];
  endfunction

  function automatic logic in_box(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return int'(diff) <= GRAB_RADIUS;
  endfunction

  always_comb begin
    w_x        = r_x;
    w_y        = r_y;
    w_closed   = r_closed;
    w_db_cnt   = r_db_cnt;
    w_lost_cnt = r_lost_cnt;
    w_lost     = r_lost;
    w_state    = r_state;
    w_vx       = r_vx;
    w_vy       = r_vy;
    w_grab     = 1'b0;
    w_release  = 1'b0;
    w_db_inc   = r_db_cnt + DCW'(1);

    if (bus.i_new_frame) begin
      if (r_seen) begin
        w_x        = smooth(r_x, r_sh_x);
        w_y        = smooth(r_y, r_sh_y);
        w_lost_cnt = '0;
        w_lost     = 1'b0;
        if (r_sh_closed != r_closed) begin
          if (w_db_inc == DCW'(DEBOUNCE_FRAMES)) begin
            w_closed = ~r_closed;
            w_db_cnt = '0;
          end else begin
            w_db_cnt = w_db_inc;
          end
        end else begin
          w_db_cnt = '0;
        end
      end else begin
        if (r_lost_cnt != LCW'(LOST_FRAMES)) w_lost_cnt = r_lost_cnt + LCW'(1);
        w_lost = (w_lost_cnt >= LCW'(LOST_FRAMES));
      end
    end

    // Ball state uses the freshly computed hand state of this update.
    case (r_state)
      ST_FREE: begin
        if (bus.i_new_frame && w_closed && !r_closed &&
            in_box(w_x, bus.i_ball_x) && in_box(w_y, bus.i_ball_y)) begin
          w_state = ST_HELD;
          w_grab  = 1'b1;
        end
      end
      ST_HELD: begin
        if (bus.i_new_frame && r_closed && !w_closed) begin
          w_state   = ST_THROWN;
          w_vx      = w_x - r_x;
          w_vy      = w_y - r_y;
          w_release = 1'b1;
        end else if (bus.i_new_frame && w_lost && !r_lost) begin
          w_state   = ST_THROWN;
          w_vx      = '0;
          w_vy      = '0;
          w_release = 1'b1;
        end
      end
      ST_THROWN: begin
        if (bus.i_ball_landed) w_state = ST_FREE;
      end
      default: w_state = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_sh_closed <= 1'b0;
      r_seen      <= 1'b0;
      r_x         <= 16'd320;
      r_y         <= 16'd240;
      r_closed    <= 1'b0;
      r_db_cnt    <= '0;
      r_lost_cnt  <= LCW'(LOST_FRAMES);
      r_lost      <= 1'b1;
      r_state     <= ST_FREE;
      r_vx        <= '0;
      r_vy        <= '0;
      r_grab      <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      // A sample coincident with new_frame is kept for the following frame.
      if (bus.i_raw_valid) begin
        r_sh_x      <= bus.i_raw_x;
        r_sh_y      <= bus.i_raw_y;
        r_sh_closed <= bus.i_raw_closed;
        r_seen      <= 1'b1;
      end else if (bus.i_new_frame) begin
        r_seen <= 1'b0;
      end
      r_x        <= w_x;
      r_y        <= w_y;
      r_closed   <= w_closed;
      r_db_cnt   <= w_db_cnt;
      r_lost_cnt <= w_lost_cnt;
      r_lost     <= w_lost;
      r_state    <= w_state;
      r_vx       <= w_vx;
      r_vy       <= w_vy;
      r_grab     <= w_grab;
      r_release  <= w_release;
    end
  end

  assign bus.o_x          = r_x;
  assign bus.o_y          = r_y;
  assign bus.o_closed     = r_closed;
  assign bus.o_ball_state = r_state;
  assign bus.o_throw_vx   = r_vx;
  assign bus.o_throw_vy   = r_vy;
  assign bus.o_grab       = r_grab;
  assign bus.o_release    = r_release;
  assign bus.o_lost       = r_lost;
endmodule

// File: tb/tb_hand_tracker.sv
// Directed bench for hand_tracker: table of per-frame vectors for smoothing/debounce,
// then hand-written sequences for grab, throw, lost drop, coincident sample and reset.
module tb_hand_tracker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hand_tracker_if hif();

  hand_tracker #(
    .SMOOTH_SHIFT(2), .DEBOUNCE_FRAMES(3), .GRAB_RADIUS(32), .LOST_FRAMES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(hif.slave)
  );

  typedef struct {
    logic        v;
    logic [15:0] rx, ry;
    logic        rc;
    logic [15:0] ex, ey;
    logic        ec;
    logic [1:0]  es;
    logic        el;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   grab_cnt = 0;
  int   rel_cnt  = 0;
  logic last_grab, last_rel;

  always @(posedge clk) begin
    if (hif.o_grab) grab_cnt++;
    if (hif.o_release) rel_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input int rx, input int ry, input logic rc,
                     input int ex, input int ey, input logic ec, input int es, input logic el);
    vec_t t;
    t.v = v; t.rx = 16'(rx); t.ry = 16'(ry); t.rc = rc;
    t.ex = 16'(ex); t.ey = 16'(ey); t.ec = ec; t.es = 2'(es); t.el = el;
    tbl.push_back(t);
  endtask

  task automatic frame(input logic v, input int fx, input int fy, input logic fc);
    @(negedge clk);
    hif.i_raw_valid = v; hif.i_raw_x = 16'(fx); hif.i_raw_y = 16'(fy); hif.i_raw_closed = fc;
    @(negedge clk);
    hif.i_raw_valid = 1'b0; hif.i_new_frame = 1'b1;
    @(negedge clk);
    hif.i_new_frame = 1'b0;
    last_grab = hif.o_grab; last_rel = hif.o_release;
    @(negedge clk);
  endtask

  task automatic coincide(input int fx, input int fy, input logic fc);
    @(negedge clk);
    hif.i_raw_valid = 1'b1; hif.i_new_frame = 1'b1;
    hif.i_raw_x = 16'(fx); hif.i_raw_y = 16'(fy); hif.i_raw_closed = fc;
    @(negedge clk);
    hif.i_raw_valid = 1'b0; hif.i_new_frame = 1'b0;
    @(negedge clk);
  endtask

  task automatic land();
    @(negedge clk);
    hif.i_ball_landed = 1'b1;
    @(negedge clk);
    hif.i_ball_landed = 1'b0;
  endtask

  task automatic set_ball(input int bx, input int by);
    hif.i_ball_x = 16'(bx); hif.i_ball_y = 16'(by);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " x"}, int'(hif.o_x), 320);
    chk({tag, " y"}, int'(hif.o_y), 240);
    chk({tag, " closed"}, int'(hif.o_closed), 0);
    chk({tag, " state"}, int'(hif.o_ball_state), 0);
    chk({tag, " vx"}, int'(hif.o_throw_vx), 0);
    chk({tag, " vy"}, int'(hif.o_throw_vy), 0);
    chk({tag, " grab"}, int'(hif.o_grab), 0);
    chk({tag, " release"}, int'(hif.o_release), 0);
    chk({tag, " lost"}, int'(hif.o_lost), 1);
  endtask

  initial begin
    int g0, r0;
    reset = 1'b1;
    hif.i_new_frame = 1'b0; hif.i_raw_valid = 1'b0; hif.i_raw_x = '0; hif.i_raw_y = '0;
    hif.i_raw_closed = 1'b0; hif.i_ball_landed = 1'b0;
    set_ball(1000, 1000);

    // Smoothing toward (400,240) then debounce: closed needs 3 consecutive disagreeing frames.
    add(1, 400, 240, 0, 340, 240, 0, 0, 0);
    add(1, 400, 240, 0, 355, 240, 0, 0, 0);
    add(1, 400, 240, 0, 366, 240, 0, 0, 0);
    add(1, 400, 240, 0, 374, 240, 0, 0, 0);
    add(1, 400, 240, 0, 380, 240, 0, 0, 0);
    add(1, 400, 240, 0, 385, 240, 0, 0, 0);
    add(1, 400, 240, 0, 388, 240, 0, 0, 0);
    add(1, 400, 240, 0, 391, 240, 0, 0, 0);
    add(1, 400, 240, 0, 393, 240, 0, 0, 0);
    add(1, 400, 240, 0, 394, 240, 0, 0, 0);
    add(1, 400, 240, 0, 395, 240, 0, 0, 0);
    add(1, 400, 240, 0, 396, 240, 0, 0, 0);
    add(1, 400, 240, 0, 397, 240, 0, 0, 0);
    add(1, 400, 240, 0, 398, 240, 0, 0, 0);
    add(1, 400, 240, 0, 399, 240, 0, 0, 0);
    add(1, 400, 240, 0, 400, 240, 0, 0, 0);
    add(1, 400, 240, 0, 400, 240, 0, 0, 0);
    add(1, 400, 240, 1, 400, 240, 0, 0, 0);
    add(1, 400, 240, 1, 400, 240, 0, 0, 0);
    add(1, 400, 240, 0, 400, 240, 0, 0, 0);
    add(1, 400, 240, 1, 400, 240, 0, 0, 0);
    add(1, 400, 240, 1, 400, 240, 0, 0, 0);
    add(1, 400, 240, 1, 400, 240, 1, 0, 0);
    add(1, 400, 240, 1, 400, 240, 1, 0, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      frame(tbl[i].v, int'(tbl[i].rx), int'(tbl[i].ry), tbl[i].rc);
      chk($sformatf("vec%0d x", i), int'(hif.o_x), int'(tbl[i].ex));
      chk($sformatf("vec%0d y", i), int'(hif.o_y), int'(tbl[i].ey));
      chk($sformatf("vec%0d closed", i), int'(hif.o_closed), int'(tbl[i].ec));
      chk($sformatf("vec%0d state", i), int'(hif.o_ball_state), int'(tbl[i].es));
      chk($sformatf("vec%0d lost", i), int'(hif.o_lost), int'(tbl[i].el));
    end

    // Grab inside the box on a fresh rise.
    repeat (40) frame(1, 100, 100, 0);
    chk("conv100 x", int'(hif.o_x), 100);
    chk("conv100 y", int'(hif.o_y), 100);
    chk("conv100 closed", int'(hif.o_closed), 0);
    set_ball(130, 70);
    g0 = grab_cnt;
    repeat (2) frame(1, 100, 100, 1);
    chk("pre-grab state", int'(hif.o_ball_state), 0);
    frame(1, 100, 100, 1);
    chk("grab closed", int'(hif.o_closed), 1);
    chk("grab state", int'(hif.o_ball_state), 1);
    chk("grab pulse", int'(last_grab), 1);
    chk("grab count", grab_cnt - g0, 1);

    repeat (3) frame(1, 100, 100, 0);
    chk("open state", int'(hif.o_ball_state), 2);
    chk("open vx", int'(hif.o_throw_vx), 0);
    chk("open release", int'(last_rel), 1);
    land();
    chk("land state", int'(hif.o_ball_state), 0);

    // Just outside the box (dx=33): no grab.
    set_ball(133, 100);
    repeat (3) frame(1, 100, 100, 1);
    chk("outside closed", int'(hif.o_closed), 1);
    chk("outside state", int'(hif.o_ball_state), 0);
    chk("outside grab", int'(last_grab), 0);
    set_ball(132, 68);
    frame(1, 100, 100, 1);
    chk("already closed state", int'(hif.o_ball_state), 0);
    repeat (3) frame(1, 100, 100, 0);
    chk("reopen closed", int'(hif.o_closed), 0);
    repeat (3) frame(1, 100, 100, 1);
    chk("edge grab state", int'(hif.o_ball_state), 1);
    chk("edge grab pulse", int'(last_grab), 1);

    // Carry to x=200, then release while moving 200 -> 215.
    repeat (40) frame(1, 200, 100, 1);
    chk("carry x", int'(hif.o_x), 200);
    chk("carry state", int'(hif.o_ball_state), 1);
    land();
    chk("land in held", int'(hif.o_ball_state), 1);
    repeat (2) frame(1, 200, 100, 0);
    chk("debounce held", int'(hif.o_ball_state), 1);
    r0 = rel_cnt;
    frame(1, 260, 100, 0);
    chk("throw x", int'(hif.o_x), 215);
    chk("throw closed", int'(hif.o_closed), 0);
    chk("throw state", int'(hif.o_ball_state), 2);
    chk("throw vx", int'(hif.o_throw_vx), 15);
    chk("throw vy", int'(hif.o_throw_vy), 0);
    chk("throw release", int'(last_rel), 1);
    chk("throw rel count", rel_cnt - r0, 1);
    land();
    chk("thrown land", int'(hif.o_ball_state), 0);

    // Hand disappears while holding: drop after 8 empty frames.
    set_ball(200, 100);
    repeat (3) frame(1, 215, 100, 1);
    chk("regrab state", int'(hif.o_ball_state), 1);
    repeat (7) frame(0, 0, 0, 0);
    chk("lost7 lost", int'(hif.o_lost), 0);
    chk("lost7 state", int'(hif.o_ball_state), 1);
    frame(0, 0, 0, 0);
    chk("lost8 lost", int'(hif.o_lost), 1);
    chk("lost8 state", int'(hif.o_ball_state), 2);
    chk("lost8 vx", int'(hif.o_throw_vx), 0);
    chk("lost8 vy", int'(hif.o_throw_vy), 0);
    chk("lost8 x", int'(hif.o_x), 215);
    chk("lost8 y", int'(hif.o_y), 100);
    chk("lost8 release", int'(last_rel), 1);

    // Sample coincident with new_frame is used by the next frame only.
    coincide(50, 50, 1);
    chk("coincide x", int'(hif.o_x), 215);
    chk("coincide y", int'(hif.o_y), 100);
    chk("coincide lost", int'(hif.o_lost), 1);
    frame(0, 0, 0, 0);
    chk("after x", int'(hif.o_x), 173);
    chk("after y", int'(hif.o_y), 87);
    chk("after lost", int'(hif.o_lost), 0);
    chk("after state", int'(hif.o_ball_state), 2);
    chk("total grabs", grab_cnt, 3);
    chk("total releases", rel_cnt, 3);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
